// File: rtl/register_q3_pkg.sv
// Shared constants for the register_q3 holding register.
package register_q3_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] REG_RESET_VALUE = '0;

endpackage

// File: rtl/register_q3_en_dff_ar.sv
// Enabled flop bank with asynchronous active-high reset.
module register_q3_en_dff_ar #(
    parameter int unsigned Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= ResetValue;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/register_q3.sv
// Single-entry holding register with a registered, read-enabled output port.
module register_q3
    import register_q3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] write_port_1,
    output logic [DATA_WIDTH-1:0] read_port_1
);

    localparam logic [DATA_WIDTH-1:0] ResetVal = DATA_WIDTH'(REG_RESET_VALUE);

    logic [DATA_WIDTH-1:0] mem_q;

    register_q3_en_dff_ar #(
        .Width      (DATA_WIDTH),
        .ResetValue (ResetVal)
    ) u_mem (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (write_enable),
        .d_i   (write_port_1),
        .q_o   (mem_q)
    );

    // Reads sample mem_q before this edge's write lands: read-before-write, no bypass.
    register_q3_en_dff_ar #(
        .Width      (DATA_WIDTH),
        .ResetValue (ResetVal)
    ) u_rd (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (read_enable),
        .d_i   (mem_q),
        .q_o   (read_port_1)
    );

endmodule

// File: tb/tb_register_q3.sv
// Randomised bench for register_q3 against a transaction-level storage model.
module tb_register_q3;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         write_enable = 1'b0;
    logic         read_enable = 1'b0;
    logic [W-1:0] write_port_1 = '0;
    logic [W-1:0] read_port_1;

    int n_vec = 0;
    int n_err = 0;

    // Reference: the stored word and the last value delivered by a read.
    logic [W-1:0] m_mem = '0;
    logic [W-1:0] m_rd  = '0;

    register_q3 #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_port_1 (write_port_1),
        .read_port_1  (read_port_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: read_port_1=%08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, then compare just after the edge.
    task automatic step(input string tag, input logic we, input logic re,
                        input logic [W-1:0] wd);
        logic [W-1:0] old_mem;
        write_enable = we;
        read_enable  = re;
        write_port_1 = wd;
        @(posedge clk);
        old_mem = m_mem;
        if (re) m_rd = old_mem;
        if (we) m_mem = wd;
        #1;
        check(tag, read_port_1, m_rd);
    endtask

    // Assert reset between edges with both enables active, hold across an edge, release.
    task automatic pulse_reset(input string tag);
        write_enable = 1'b1;
        read_enable  = 1'b1;
        write_port_1 = $urandom;
        #2;
        rst = 1'b1;
        m_mem = '0;
        m_rd  = '0;
        #1;
        check({tag, "_async"}, read_port_1, '0);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, read_port_1, '0);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        check("por", read_port_1, '0);
        #2;
        rst = 1'b0;

        // Reset with all-ones data and both enables high.
        step("pre_rst_fill", 1'b1, 1'b1, 32'hFFFF_FFFF);
        step("pre_rst_rd", 1'b0, 1'b1, 32'h0);
        pulse_reset("rst1");
        step("rst1_rd_nowr", 1'b0, 1'b1, 32'h0);
        check("rst1_rd_zero", read_port_1, 32'h0);

        // Basic write then read.
        step("wr_abcde", 1'b1, 1'b0, 32'h000A_BCDE);
        step("rd_abcde", 1'b0, 1'b1, 32'h0);
        check("rd_abcde_lit", read_port_1, 32'h000A_BCDE);

        // Hold on disabled read.
        step("hold_rd", 1'b1, 1'b0, 32'h0001_2345);
        check("hold_rd_lit", read_port_1, 32'h000A_BCDE);
        step("rd_12345", 1'b0, 1'b1, 32'h0);
        check("rd_12345_lit", read_port_1, 32'h0001_2345);

        // Simultaneous write and read.
        step("wr_abcde2", 1'b1, 1'b0, 32'h000A_BCDE);
        step("rw_same", 1'b1, 1'b1, 32'h0001_2345);
        check("rw_same_lit", read_port_1, 32'h000A_BCDE);
        step("rw_next", 1'b0, 1'b1, 32'h0);
        check("rw_next_lit", read_port_1, 32'h0001_2345);

        // Disabled write.
        for (int i = 0; i < 3; i++) step("nowr", 1'b0, 1'b0, 32'hDEAD_BEEF);
        step("nowr_rd", 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("nowr_rd_lit", read_port_1, 32'h0001_2345);

        // Mid-operation reset.
        step("wr_cafe", 1'b1, 1'b0, 32'hCAFE_F00D);
        pulse_reset("rst2");
        step("rst2_rd", 1'b0, 1'b1, 32'h0);
        check("rst2_rd_lit", read_port_1, 32'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
